// File: rtl/display_mux.sv
// Multiplexed driver for a common-anode 4-digit 7-segment display showing hh:mm.
// Digits are snapshotted once per frame, with dead time, colon blink, leading-zero and edit blanking.
module display_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 16,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hour1,
  input  logic [3:0] hour0,
  input  logic [2:0] min1,
  input  logic [3:0] min0,
  input  logic       blank_lz,
  input  logic       edit_en,
  input  logic [1:0] edit_digit,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_done
);
  localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);
  localparam logic [RC_W-1:0] RC_DEAD = RC_W'(DEAD_CYC);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

  logic [RC_W-1:0] rc_q, rc_d;
  logic [1:0]      idx_q, idx_d;
  logic [BL_W-1:0] blink_q, blink_d;
  logic            phase_q, phase_d;
  logic            snap_pend_q, snap_pend_d;
  logic [1:0]      sh_hour1_q, sh_hour1_d;
  logic [3:0]      sh_hour0_q, sh_hour0_d;
  logic [2:0]      sh_min1_q, sh_min1_d;
  logic [3:0]      sh_min0_q, sh_min0_d;
  logic [3:0]      an_n_q, an_n_d;
  logic [6:0]      seg_n_q, seg_n_d;
  logic            dp_n_q, dp_n_d;
  logic            frame_done_q, frame_done_d;

  logic       rc_wrap, frame_wrap, snap, blink_wrap;
  logic       digit_on, lz_blank, edit_blank, invalid;
  logic [3:0] digit;
  logic [6:0] seg_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q         <= '0;
      idx_q        <= 2'd0;
      blink_q      <= '0;
      phase_q      <= 1'b0;
      snap_pend_q  <= 1'b1;
      sh_hour1_q   <= 2'd0;
      sh_hour0_q   <= 4'd0;
      sh_min1_q    <= 3'd0;
      sh_min0_q    <= 4'd0;
      an_n_q       <= 4'hF;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      rc_q         <= rc_d;
      idx_q        <= idx_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      snap_pend_q  <= snap_pend_d;
      sh_hour1_q   <= sh_hour1_d;
      sh_hour0_q   <= sh_hour0_d;
      sh_min1_q    <= sh_min1_d;
      sh_min0_q    <= sh_min0_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Scan timing, blink timebase and snapshot control.
  always_comb begin
    rc_wrap      = (rc_q == RC_LAST);
    frame_wrap   = rc_wrap && (idx_q == 2'd3);
    blink_wrap   = (blink_q == BL_LAST);
    rc_d         = rc_wrap ? '0 : rc_q + 1'b1;
    idx_d        = rc_wrap ? idx_q + 2'd1 : idx_q;
    blink_d      = blink_wrap ? '0 : blink_q + 1'b1;
    phase_d      = phase_q ^ blink_wrap;
    snap         = snap_pend_q || frame_wrap;
    snap_pend_d  = 1'b0;
    sh_hour1_d   = snap ? hour1 : sh_hour1_q;
    sh_hour0_d   = snap ? hour0 : sh_hour0_q;
    sh_min1_d    = snap ? min1  : sh_min1_q;
    sh_min0_d    = snap ? min0  : sh_min0_q;
    frame_done_d = frame_wrap;
  end

  // Select the active shadow digit; hour tens of 3 and minute tens of 6/7 cannot occur on a clock.
  always_comb begin
    digit   = 4'd0;
    invalid = 1'b0;
    case (idx_q)
      2'd0: digit = sh_min0_q;
      2'd1: begin
        digit   = {1'b0, sh_min1_q};
        invalid = (sh_min1_q >= 3'd6);
      end
      2'd2: digit = sh_hour0_q;
      default: begin
        digit   = {2'b00, sh_hour1_q};
        invalid = (sh_hour1_q == 2'd3);
      end
    endcase
  end

  always_comb begin
    case (digit)
      4'd0:    seg_raw = 7'h40;
      4'd1:    seg_raw = 7'h79;
      4'd2:    seg_raw = 7'h24;
      4'd3:    seg_raw = 7'h30;
      4'd4:    seg_raw = 7'h19;
      4'd5:    seg_raw = 7'h12;
      4'd6:    seg_raw = 7'h02;
      4'd7:    seg_raw = 7'h78;
      4'd8:    seg_raw = 7'h00;
      4'd9:    seg_raw = 7'h10;
      default: seg_raw = 7'h3F;
    endcase
  end

  always_comb begin
    lz_blank   = (idx_q == 2'd3) && blank_lz && (sh_hour1_q == 2'd0);
    edit_blank = edit_en && (edit_digit == idx_q) && !phase_q;
    digit_on   = (rc_q >= RC_DEAD) && !lz_blank && !edit_blank;
    an_n_d     = digit_on ? ~(4'b0001 << idx_q) : 4'hF;
    seg_n_d    = invalid ? 7'h3F : seg_raw;
    dp_n_d     = !(digit_on && (idx_q == 2'd2) && phase_q);
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_display_mux.sv
// Self-checking bench for display_mux: an arithmetic reference model queues the expected
// outputs on each clock edge and every scenario task pops and compares them on the falling edge.
module tb_display_mux;
  localparam int RD = 8;
  localparam int DC = 2;
  localparam int BD = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] hour1 = 2'd0;
  logic [3:0] hour0 = 4'd0;
  logic [2:0] min1 = 3'd0;
  logic [3:0] min0 = 4'd0;
  logic       blank_lz = 1'b0;
  logic       edit_en = 1'b0;
  logic [1:0] edit_digit = 2'd0;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       frame_done;

  display_mux #(.REFRESH_DIV(RD), .DEAD_CYC(DC), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .hour1(hour1), .hour0(hour0), .min1(min1), .min0(min0),
    .blank_lz(blank_lz), .edit_en(edit_en), .edit_digit(edit_digit),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int m_k = 0;
  int s_h1 = 0, s_h0 = 0, s_m1 = 0, s_m0 = 0;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Reference model: the n-th edge after reset release sees rc=n%RD, idx=(n/RD)%4, phase=(n/BD)%2.
  always @(posedge clk) begin : model
    exp_t e;
    int n, rc, idx, ph, v;
    bit bad, on;
    if (rst) begin
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
      m_k = 0;
      s_h1 = 0; s_h0 = 0; s_m1 = 0; s_m0 = 0;
    end else begin
      n = m_k;
      m_k++;
      rc = n % RD;
      idx = (n / RD) % 4;
      ph = (n / BD) % 2;
      case (idx)
        0: v = s_m0;
        1: v = s_m1;
        2: v = s_h0;
        default: v = s_h1;
      endcase
      bad = (idx == 1 && s_m1 >= 6) || (idx == 3 && s_h1 == 3);
      on = (rc >= DC) && !(idx == 3 && blank_lz && s_h1 == 0)
           && !(edit_en && int'(edit_digit) == idx && ph == 0);
      e.an = on ? 4'(~(4'b0001 << idx)) : 4'hF;
      e.seg = !on ? 7'h7F : (bad ? 7'h3F : seg_of(v));
      e.dp = !(on && idx == 2 && ph == 1);
      e.fd = (n % (4 * RD) == 4 * RD - 1);
      if (n == 0 || e.fd) begin
        s_h1 = int'(hour1); s_h0 = int'(hour0); s_m1 = int'(min1); s_m0 = int'(min0);
      end
    end
    exp_q.push_back(e);
  end

  task automatic test_reset();
    exp_t e, got;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    @(negedge clk);
    if (exp_q.size() == 0) begin fails++; $display("FAIL reset: no expectation queued"); end
    else begin
      e = exp_q.pop_front(); tests++;
      got = {an_n, seg_n, dp_n, frame_done};
      if (got !== e) begin fails++; $display("FAIL reset: got %h want %h", got, e); end
    end
    tests++;
    if ({an_n, seg_n, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++; $display("FAIL reset_const: got an=%h seg=%h dp=%b fd=%b want F/7F/1/0", an_n, seg_n, dp_n, frame_done);
    end
    hour1 = 2'd1; hour0 = 4'd2; min1 = 3'd3; min0 = 4'd4;
    rst = 1'b0;
  endtask

  task automatic test_scan();
    exp_t e, got;
    int last = -1;
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin fails++; $display("FAIL scan: no expectation queued"); end
      else begin
        e = exp_q.pop_front(); tests++;
        got = {an_n, (e.an == 4'hF) ? 7'h7F : seg_n, dp_n, frame_done};
        if (got !== e) begin fails++; $display("FAIL scan cyc %0d: got %h want %h", i, got, e); end
      end
      if (frame_done === 1'b1) begin
        if (last >= 0) begin
          tests++;
          if (i - last != 4 * RD) begin fails++; $display("FAIL frame_period: got %0d want %0d", i - last, 4 * RD); end
        end
        last = i;
      end
    end
  endtask

  task automatic test_snapshot();
    exp_t e, got;
    int shown5 = 0;
    bit changed = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin fails++; $display("FAIL snapshot: no expectation queued"); end
      else begin
        e = exp_q.pop_front(); tests++;
        got = {an_n, (e.an == 4'hF) ? 7'h7F : seg_n, dp_n, frame_done};
        if (got !== e) begin fails++; $display("FAIL snapshot cyc %0d: got %h want %h", i, got, e); end
      end
      if (changed && an_n == 4'hE && seg_n == 7'h12) shown5++;
      if (!changed && (m_k / RD) % 4 == 1 && m_k % RD == 3) begin
        min0 = 4'd5;
        changed = 1;
      end
    end
    tests++;
    if (!changed || shown5 == 0) begin fails++; $display("FAIL snapshot_new: got %0d lit cycles of 12 want >0", shown5); end
  endtask

  task automatic test_blank_lz();
    exp_t e, got;
    int seen7 = 0, lit0 = 0;
    bit armed = 0;
    hour1 = 2'd0; blank_lz = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 80) begin blank_lz = 1'b0; end
      if (exp_q.size() == 0) begin fails++; $display("FAIL blank_lz: no expectation queued"); end
      else begin
        e = exp_q.pop_front(); tests++;
        got = {an_n, (e.an == 4'hF) ? 7'h7F : seg_n, dp_n, frame_done};
        if (got !== e) begin fails++; $display("FAIL blank_lz cyc %0d: got %h want %h", i, got, e); end
      end
      if (armed && i < 80 && an_n == 4'h7) seen7++;
      if (i > 81 && an_n == 4'h7 && seg_n == 7'h40) lit0++;
      if (frame_done === 1'b1) armed = 1;
    end
    tests++;
    if (seen7 != 0) begin fails++; $display("FAIL lz_blanked: got %0d cycles an_n=7 want 0", seen7); end
    tests++;
    if (lit0 == 0) begin fails++; $display("FAIL lz_shown: got %0d cycles of 40 want >0", lit0); end
  endtask

  task automatic test_invalid();
    exp_t e, got;
    int dashes = 0;
    bit armed = 0;
    hour1 = 2'd3; hour0 = 4'd12; min1 = 3'd6; min0 = 4'd9;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin fails++; $display("FAIL invalid: no expectation queued"); end
      else begin
        e = exp_q.pop_front(); tests++;
        got = {an_n, (e.an == 4'hF) ? 7'h7F : seg_n, dp_n, frame_done};
        if (got !== e) begin fails++; $display("FAIL invalid cyc %0d: got %h want %h", i, got, e); end
      end
      if (armed && (an_n == 4'hD || an_n == 4'hB || an_n == 4'h7) && seg_n == 7'h3F) dashes++;
      if (frame_done === 1'b1) armed = 1;
    end
    tests++;
    if (dashes < 3 * (RD - DC)) begin fails++; $display("FAIL dash_count: got %0d want >=%0d", dashes, 3 * (RD - DC)); end
  endtask

  task automatic test_edit();
    exp_t e, got;
    int lit1 = 0, colon = 0;
    hour1 = 2'd1; hour0 = 4'd7; min1 = 3'd5; min0 = 4'd8;
    edit_en = 1'b1; edit_digit = 2'd1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin fails++; $display("FAIL edit: no expectation queued"); end
      else begin
        e = exp_q.pop_front(); tests++;
        got = {an_n, (e.an == 4'hF) ? 7'h7F : seg_n, dp_n, frame_done};
        if (got !== e) begin fails++; $display("FAIL edit cyc %0d: got %h want %h", i, got, e); end
      end
      if (an_n == 4'hD) lit1++;
      if (dp_n == 1'b0) colon++;
    end
    tests++;
    if (lit1 == 0 || colon == 0) begin fails++; $display("FAIL edit_activity: got lit=%0d colon=%0d want both >0", lit1, colon); end
    edit_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e, got;
    bit hit = 0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin fails++; $display("FAIL reset_mid_wait: no expectation queued"); end
      else begin
        e = exp_q.pop_front(); tests++;
        got = {an_n, (e.an == 4'hF) ? 7'h7F : seg_n, dp_n, frame_done};
        if (got !== e) begin fails++; $display("FAIL reset_mid_wait cyc %0d: got %h want %h", i, got, e); end
      end
      if ((m_k / RD) % 4 == 2 && m_k % RD == 4) hit = 1;
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL reset_mid_timeout: got no idx=2 slot want one within 64 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    tests++;
    if ({an_n, seg_n, dp_n} !== {4'hF, 7'h7F, 1'b1}) begin
      fails++; $display("FAIL reset_mid: got an=%h seg=%h dp=%b want F/7F/1", an_n, seg_n, dp_n);
    end
    hour1 = 2'd2; hour0 = 4'd3; min1 = 3'd5; min0 = 4'd9;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin fails++; $display("FAIL reset_mid_restart: no expectation queued"); end
      else begin
        e = exp_q.pop_front(); tests++;
        got = {an_n, (e.an == 4'hF) ? 7'h7F : seg_n, dp_n, frame_done};
        if (got !== e) begin fails++; $display("FAIL reset_mid_restart cyc %0d: got %h want %h", i, got, e); end
      end
      if (i == 4) begin
        tests++;
        if (an_n !== 4'hE || seg_n !== 7'h10) begin
          fails++; $display("FAIL restart_idx0: got an=%h seg=%h want E/10", an_n, seg_n);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_blank_lz();
    test_invalid();
    test_edit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
